// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter serialising two masters onto one SRAM controller port.
// Ack is taken no earlier than ACK_HOLDOFF+1 edges after grant and the request aborts at TIMEOUT; a RELEASE cycle separates transactions.
module sram_port_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 48,
  parameter int ACK_HOLDOFF = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  output logic [DATA_W-1:0] m0_dout,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  output logic [DATA_W-1:0] m1_dout,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout,
  input  logic              s_ack,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [7:0] HOLDOFF_C = 8'(ACK_HOLDOFF);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       last;
  logic       take, pick, done_ack, done_err;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // last==1 means master 1 owned the previous transaction, so master 0 wins a tie.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = 1'b0;
    done_ack  = 1'b0;
    done_err  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_stb || m1_stb) begin
          take      = 1'b1;
          pick      = m1_stb && (!m0_stb || !last);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt >= HOLDOFF_C && s_ack) begin
          done_ack  = 1'b1;
          state_nxt = RELEASE;
        end else if (cnt == TIMEOUT_C) begin
          done_err  = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      s_stb   <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_din   <= '0;
      grant   <= 2'b00;
      last    <= 1'b1;
      cnt     <= 8'd0;
      m0_dout <= '0;
      m1_dout <= '0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      if (take) begin
        s_stb  <= 1'b1;
        s_we   <= pick ? m1_we   : m0_we;
        s_addr <= pick ? m1_addr : m0_addr;
        s_din  <= pick ? m1_din  : m0_din;
        grant  <= pick ? 2'b10 : 2'b01;
        last   <= pick;
        cnt    <= 8'd0;
      end
      if (state == BUSY && cnt != 8'hFF) cnt <= cnt + 8'd1;
      // Completion data is captured for writes too; the controller defines s_dout then.
      if (done_ack) begin
        s_stb <= 1'b0;
        if (grant[1]) begin
          m1_ack  <= 1'b1;
          m1_dout <= s_dout;
        end else begin
          m0_ack  <= 1'b1;
          m0_dout <= s_dout;
        end
      end
      if (done_err) begin
        s_stb <= 1'b0;
        if (grant[1]) m1_err <= 1'b1;
        else          m0_err <= 1'b1;
      end
      if (state == RELEASE) grant <= 2'b00;
    end
  end

endmodule
